page_match_checker: RTL and testbench

PAGE_MATCH_CHECKER -- requirements
Module: page_match_checker

---
 rtl/page_match_checker.sv | 134 +++++++++++++
 tb/tb_page_match_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_match_checker.sv
// Streams an original page and a decompressed page side by side, buffering the
// original bytes in a small FIFO and tallying equal byte pairs per page.
module page_match_checker #(
  parameter int PAGE_BYTES = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  origData,
  input  logic        origValid,
  output logic        origReady,
  input  logic [7:0]  decompData,
  input  logic        decompValid,
  output logic        decompReady,
  output logic [12:0] numberOfMatchingBytes,
  output logic [11:0] firstMismatchIndex,
  output logic        mismatchFound,
  output logic        busy,
  output logic        finished
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT             stateReg;
  stateT             stateNext;
  logic [ADDR_W:0]   wrPtrReg;
  logic [ADDR_W:0]   rdPtrReg;
  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [12:0]       compareCountReg;
  logic [12:0]       origAcceptCountReg;
  logic [12:0]       matchCountReg;
  logic [11:0]       firstMismatchReg;
  logic              mismatchReg;

  logic              fifoEmpty;
  logic              fifoFull;
  logic              push;
  logic              pop;
  logic              startAccepted;
  logic              lastCompare;
  logic [7:0]        headData;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign fifoEmpty = (wrPtrReg == rdPtrReg);
  assign fifoFull  = (wrPtrReg[ADDR_W] != rdPtrReg[ADDR_W]) &&
                     (wrPtrReg[ADDR_W-1:0] == rdPtrReg[ADDR_W-1:0]);

  assign push          = origValid && origReady;
  assign pop           = decompValid && decompReady;
  assign headData      = fifoMem[rdPtrReg[ADDR_W-1:0]];
  assign startAccepted = start && (stateReg != RUN);
  assign lastCompare   = pop && (compareCountReg == 13'(PAGE_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastCompare) stateNext = DONE;
      DONE:    if (start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // Readies depend only on registered state so no valid-to-ready path exists.
  always_comb begin
    origReady   = (stateReg == RUN) && !fifoFull &&
                  (origAcceptCountReg < 13'(PAGE_BYTES));
    decompReady = (stateReg == RUN) && !fifoEmpty;
    busy        = (stateReg == RUN);
    finished    = (stateReg == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtrReg           <= '0;
      rdPtrReg           <= '0;
      compareCountReg    <= '0;
      origAcceptCountReg <= '0;
      matchCountReg      <= '0;
      firstMismatchReg   <= '0;
      mismatchReg        <= 1'b0;
    end else if (startAccepted) begin
      wrPtrReg           <= '0;
      rdPtrReg           <= '0;
      compareCountReg    <= '0;
      origAcceptCountReg <= '0;
      matchCountReg      <= '0;
      firstMismatchReg   <= '0;
      mismatchReg        <= 1'b0;
    end else begin
      if (push) begin
        wrPtrReg           <= wrPtrReg + 1'b1;
        origAcceptCountReg <= origAcceptCountReg + 13'd1;
      end
      if (pop) begin
        rdPtrReg        <= rdPtrReg + 1'b1;
        compareCountReg <= compareCountReg + 13'd1;
        if (headData == decompData) begin
          matchCountReg <= matchCountReg + 13'd1;
        end else if (!mismatchReg) begin
          firstMismatchReg <= compareCountReg[11:0];
          mismatchReg      <= 1'b1;
        end
      end
    end
  end

  // Per-entry write enables; storage needs no reset since pointers gate reads.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gFifoEntry
      always_ff @(posedge clock) begin
        if (push && (wrPtrReg[ADDR_W-1:0] == ADDR_W'(gi))) begin
          fifoMem[gi] <= origData;
        end
      end
    end
  endgenerate

  assign numberOfMatchingBytes = matchCountReg;
  assign firstMismatchIndex    = firstMismatchReg;
  assign mismatchFound         = mismatchReg;

endmodule

// File: tb/tb_page_match_checker.sv
// Directed bench for page_match_checker: drives both byte streams, tracks
// handshakes itself and compares page results with hand-computed values.
module tb_page_match_checker;

  localparam int PAGE = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  origData;
  logic        origValid;
  logic        origReady;
  logic [7:0]  decompData;
  logic        decompValid;
  logic        decompReady;
  logic [12:0] numberOfMatchingBytes;
  logic [11:0] firstMismatchIndex;
  logic        mismatchFound;
  logic        busy;
  logic        finished;

  int assertCount = 0;
  int failCount   = 0;
  int origIdx     = 0;
  int decIdx      = 0;

  always #5 clock = ~clock;

  page_match_checker #(.PAGE_BYTES(PAGE), .FIFO_DEPTH(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .origData              (origData),
    .origValid             (origValid),
    .origReady             (origReady),
    .decompData            (decompData),
    .decompValid           (decompValid),
    .decompReady           (decompReady),
    .numberOfMatchingBytes (numberOfMatchingBytes),
    .firstMismatchIndex    (firstMismatchIndex),
    .mismatchFound         (mismatchFound),
    .busy                  (busy),
    .finished              (finished)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7) ^ (i >> 5));
  endfunction

  task automatic startPage();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    origIdx = 0;
    decIdx  = 0;
  endtask

  // Drives both streams until DONE, until decIdx reaches stopAt, or budget expires.
  task automatic runPage(input int stopAt, input bit pulseStart, input int mis0,
                         input int mis1, input int stallAt, input int stallLen,
                         input bit sparseOrig, output bit timedOut);
    int  stallCnt;
    bit  doPush;
    bit  doPop;
    bit  stalled;
    stallCnt = 0;
    timedOut = 1'b1;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(negedge clock);
      if (finished) begin
        timedOut = 1'b0;
        break;
      end
      stalled     = (decIdx >= stallAt) && (stallCnt < stallLen);
      origValid   = (origIdx < PAGE) && !(sparseOrig && (cyc % 3 == 0));
      origData    = pat(origIdx);
      decompValid = !stalled && (decIdx < PAGE);
      decompData  = pat(decIdx) ^ (((decIdx == mis0) || (decIdx == mis1)) ? 8'hFF : 8'h00);
      start       = pulseStart && (cyc == 0);
      doPush      = origValid && origReady;
      doPop       = decompValid && decompReady;
      @(posedge clock);
      if (doPush) origIdx++;
      if (doPop) decIdx++;
      if (stalled) stallCnt++;
      if (decIdx == stopAt) begin
        timedOut = 1'b0;
        break;
      end
    end
    #1;
    start       = 1'b0;
    origValid   = 1'b0;
    decompValid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    assertCount++;
    if ({origReady, decompReady, busy, finished, mismatchFound, numberOfMatchingBytes,
         firstMismatchIndex} !== 30'd0) begin
      failCount++;
      $display("FAIL reset_state: outputs=%h expected 0", {origReady, decompReady, busy,
               finished, mismatchFound, numberOfMatchingBytes, firstMismatchIndex});
    end
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    assertCount++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("FAIL start_during_reset: busy=%b expected 0", busy);
    end
    startPage();
    assertCount++;
    if ({busy, origReady, decompReady} !== 3'b110) begin
      failCount++;
      $display("FAIL run_entry: busy/origReady/decompReady=%b expected 110",
               {busy, origReady, decompReady});
    end
  endtask

  task automatic test_identical_page();
    bit to;
    runPage(-1, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || finished !== 1'b1) begin
      failCount++;
      $display("FAIL identical_done: timeout=%b finished=%b expected 0/1", to, finished);
    end
    assertCount++;
    if (numberOfMatchingBytes !== 13'd4096 || mismatchFound !== 1'b0) begin
      failCount++;
      $display("FAIL identical_count: matches=%0d mismatch=%b expected 4096/0",
               numberOfMatchingBytes, mismatchFound);
    end
    assertCount++;
    if (decIdx != PAGE || origIdx != PAGE) begin
      failCount++;
      $display("FAIL identical_handshakes: compares=%0d pushes=%0d expected 4096/4096",
               decIdx, origIdx);
    end
    origValid   = 1'b1;
    decompValid = 1'b1;
    repeat (5) @(negedge clock);
    assertCount++;
    if ({origReady, decompReady, finished} !== 3'b001 || numberOfMatchingBytes !== 13'd4096) begin
      failCount++;
      $display("FAIL done_hold: readies/finished=%b matches=%0d expected 001/4096",
               {origReady, decompReady, finished}, numberOfMatchingBytes);
    end
    origValid   = 1'b0;
    decompValid = 1'b0;
  endtask

  task automatic test_mismatch(input string name, input int mis0, input int mis1,
                               input bit sparseOrig, input int expMatch, input int expFirst);
    bit to;
    startPage();
    runPage(-1, 1'b0, mis0, mis1, 0, 0, sparseOrig, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'(expMatch)) begin
      failCount++;
      $display("FAIL %s_count: timeout=%b matches=%0d expected 0/%0d", name, to,
               numberOfMatchingBytes, expMatch);
    end
    assertCount++;
    if (firstMismatchIndex !== 12'(expFirst) || mismatchFound !== 1'b1) begin
      failCount++;
      $display("FAIL %s_first: index=%0d found=%b expected %0d/1", name,
               firstMismatchIndex, mismatchFound, expFirst);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    startPage();
    assertCount++;
    if ({busy, finished, mismatchFound} !== 3'b100 || numberOfMatchingBytes !== 13'd0 ||
        firstMismatchIndex !== 12'd0) begin
      failCount++;
      $display("FAIL restart_clear: busy/fin/mm=%b matches=%0d index=%0d expected 100/0/0",
               {busy, finished, mismatchFound}, numberOfMatchingBytes, firstMismatchIndex);
    end
    runPage(-1, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd4096 || mismatchFound !== 1'b0) begin
      failCount++;
      $display("FAIL restart_page: timeout=%b matches=%0d mm=%b expected 0/4096/0", to,
               numberOfMatchingBytes, mismatchFound);
    end
  endtask

  task automatic test_decomp_stall();
    bit to;
    bit doPush;
    startPage();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      origValid   = 1'b1;
      origData    = pat(origIdx);
      decompValid = 1'b0;
      doPush      = origReady;
      @(posedge clock);
      if (doPush) origIdx++;
    end
    @(negedge clock);
    origValid = 1'b0;
    assertCount++;
    if (origIdx != 4 || origReady !== 1'b0 || decompReady !== 1'b1) begin
      failCount++;
      $display("FAIL stall_fill: pushes=%0d origReady=%b decompReady=%b expected 4/0/1",
               origIdx, origReady, decompReady);
    end
    runPage(-1, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd4096 || decIdx != PAGE) begin
      failCount++;
      $display("FAIL stall_page: timeout=%b matches=%0d compares=%0d expected 0/4096/4096",
               to, numberOfMatchingBytes, decIdx);
    end
  endtask

  task automatic test_reset_mid_page();
    bit to;
    startPage();
    runPage(2000, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd2000) begin
      failCount++;
      $display("FAIL mid_page_count: timeout=%b matches=%0d expected 0/2000", to,
               numberOfMatchingBytes);
    end
    reset = 1'b1;
    #1;
    assertCount++;
    if ({origReady, decompReady, busy, finished, mismatchFound, numberOfMatchingBytes,
         firstMismatchIndex} !== 30'd0) begin
      failCount++;
      $display("FAIL async_reset: outputs=%h expected 0", {origReady, decompReady, busy,
               finished, mismatchFound, numberOfMatchingBytes, firstMismatchIndex});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    assertCount++;
    if ({busy, finished, origReady, decompReady} !== 4'b0000) begin
      failCount++;
      $display("FAIL reset_idle: busy/fin/oR/dR=%b expected 0000",
               {busy, finished, origReady, decompReady});
    end
    startPage();
    runPage(-1, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd4096 || finished !== 1'b1) begin
      failCount++;
      $display("FAIL after_reset_page: timeout=%b matches=%0d fin=%b expected 0/4096/1", to,
               numberOfMatchingBytes, finished);
    end
  endtask

  task automatic test_start_during_run();
    bit to;
    startPage();
    runPage(1000, 1'b0, -1, -1, 0, 0, 1'b0, to);
    runPage(1001, 1'b1, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd1001 || busy !== 1'b1) begin
      failCount++;
      $display("FAIL start_in_run: timeout=%b matches=%0d busy=%b expected 0/1001/1", to,
               numberOfMatchingBytes, busy);
    end
    runPage(-1, 1'b0, -1, -1, 0, 0, 1'b0, to);
    assertCount++;
    if (to !== 1'b0 || numberOfMatchingBytes !== 13'd4096 || decIdx != PAGE) begin
      failCount++;
      $display("FAIL start_in_run_page: timeout=%b matches=%0d compares=%0d expected 0/4096/4096",
               to, numberOfMatchingBytes, decIdx);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    origData    = 8'h00;
    origValid   = 1'b0;
    decompData  = 8'h00;
    decompValid = 1'b0;
    test_reset();
    test_identical_page();
    test_mismatch("mismatch_100", 100, -1, 1'b0, 4095, 100);
    test_mismatch("mismatch_5_4095", 5, 4095, 1'b0, 4094, 5);
    test_mismatch("mismatch_last", 4095, -1, 1'b0, 4095, 4095);
    test_back_to_back();
    test_mismatch("sparse_first", 0, -1, 1'b1, 4095, 0);
    test_decomp_stall();
    test_reset_mid_page();
    test_start_during_run();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
